// File: rtl/pll_lock_clk_div.sv
// pll_lock_clk_div
//   Lock-qualified clock-enable generator in the PLL output clock domain.
//   PLL LOCK is synchronised and must stay high for LOCK_CYCLES consecutive
//   cycles before downstream reset is released. NUM_CH independent channels
//   then emit one-cycle enable strobes every D cycles, plus a toggle output.
//   Divisors reload glitch-free through a shadow register.
// Ports:
//   clk        PLL output clock (sole clock)
//   rst        synchronous active-high reset
//   pll_lock   PLL LOCK, asynchronous to clk
//   div_load   per-channel divisor load strobe
//   div_value  channel i divisor at [i*DIV_W +: DIV_W]
//   ce_out     per-channel one-cycle clock-enable strobes
//   tgl_out    per-channel toggle, inverts on each ce_out pulse
//   rst_out    synchronous active-high reset for downstream logic
//   locked     high while in RUN
//   loss_cnt   saturating count of lock losses while in RUN
module pll_lock_clk_div #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int LOCK_CYCLES = 1024,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pll_lock,
  input  logic [NUM_CH-1:0]       div_load,
  input  logic [NUM_CH*DIV_W-1:0] div_value,
  output logic [NUM_CH-1:0]       ce_out,
  output logic [NUM_CH-1:0]       tgl_out,
  output logic                    rst_out,
  output logic                    locked,
  output logic [7:0]              loss_cnt
);

  localparam int CW = $clog2(LOCK_CYCLES);

  typedef enum logic [1:0] {WAIT_LOCK, STABLE, RUN} state_t;

  state_t          state_q, state_d;
  logic            sync1_q, lock_s_q;
  logic [CW-1:0]   stab_q, stab_d;
  logic            rst_out_q, rst_out_d;
  logic            locked_q, locked_d;
  logic [7:0]      loss_q, loss_d;

  logic [NUM_CH-1:0][DIV_W-1:0] act_q, act_d;
  logic [NUM_CH-1:0][DIV_W-1:0] sh_q, sh_d;
  logic [NUM_CH-1:0][DIV_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0][DIV_W-1:0] deff, nxt;
  logic [NUM_CH-1:0]            pend_q, pend_d;
  logic [NUM_CH-1:0]            ce_q, ce_d;
  logic [NUM_CH-1:0]            tgl_q, tgl_d;

  // State register, synchroniser and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      lock_s_q  <= 1'b0;
      state_q   <= WAIT_LOCK;
      stab_q    <= '0;
      rst_out_q <= 1'b1;
      locked_q  <= 1'b0;
      loss_q    <= '0;
    end else begin
      sync1_q   <= pll_lock;
      lock_s_q  <= sync1_q;
      state_q   <= state_d;
      stab_q    <= stab_d;
      rst_out_q <= rst_out_d;
      locked_q  <= locked_d;
      loss_q    <= loss_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    unique case (state_q)
      WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d = STABLE;
          stab_d  = CW'(1);
        end
      end
      STABLE: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
          stab_d  = '0;
        end else if (stab_q == CW'(LOCK_CYCLES - 1)) begin
          state_d = RUN;
          stab_d  = '0;
        end else begin
          stab_d  = stab_q + CW'(1);
        end
      end
      RUN: begin
        if (!lock_s_q) begin
          state_d = WAIT_LOCK;
          stab_d  = '0;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        stab_d  = '0;
      end
    endcase
  end

  // Output logic: computed from the next state so the registered outputs
  // change on the very edge that enters or leaves RUN
  always_comb begin
    rst_out_d = (state_d != RUN);
    locked_d  = (state_d == RUN);
    loss_d    = loss_q;
    if (state_q == RUN && state_d != RUN && loss_q != 8'hFF)
      loss_d = loss_q + 8'd1;
  end

  // Channel dividers. cnt_q holds the position of the current RUN cycle
  // within its period (1..D); it restarts at 1 after every pulse and on
  // RUN entry. Outside RUN a pending shadow value is already in force for
  // the entry edge, so the first period after lock uses it.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      deff[i]  = (state_q != RUN && pend_q[i]) ? sh_q[i] : act_q[i];
      nxt[i]   = (state_q == RUN && !ce_q[i]) ? cnt_q[i] + DIV_W'(1) : DIV_W'(1);
      ce_d[i]  = (state_d == RUN) && (nxt[i] >= deff[i]);
      cnt_d[i] = (state_d == RUN) ? nxt[i] : '0;
      tgl_d[i] = (state_d == RUN) ? (tgl_q[i] ^ ce_d[i]) : 1'b0;
      act_d[i] = act_q[i];
      sh_d[i]  = sh_q[i];
      pend_d[i] = pend_q[i];
      // In RUN the swap waits for the terminal-count edge so the running
      // period always completes with the old divisor.
      if (pend_q[i] && (state_q != RUN || ce_d[i])) begin
        act_d[i]  = sh_q[i];
        pend_d[i] = 1'b0;
      end
      // A load on the swap edge lands in the shadow and waits for the next
      // terminal count.
      if (div_load[i]) begin
        sh_d[i]   = div_value[i*DIV_W +: DIV_W];
        pend_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        act_q[i] <= DIV_W'(DEFAULT_DIV);
        sh_q[i]  <= DIV_W'(DEFAULT_DIV);
        cnt_q[i] <= '0;
      end
      pend_q <= '0;
      ce_q   <= '0;
      tgl_q  <= '0;
    end else begin
      act_q  <= act_d;
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      ce_q   <= ce_d;
      tgl_q  <= tgl_d;
    end
  end

  assign ce_out   = ce_q;
  assign tgl_out  = tgl_q;
  assign rst_out  = rst_out_q;
  assign locked   = locked_q;
  assign loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_lock_clk_div.sv
// tb_pll_lock_clk_div
//   Self-checking bench for pll_lock_clk_div: directed scenarios plus a
//   randomized phase, all outputs compared every cycle against a
//   cycle-level behavioural model of the lock qualification and dividers.
module tb_pll_lock_clk_div;

  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int LC  = 8;
  localparam int DEF = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              pll_lock;
  logic [NCH-1:0]    div_load;
  logic [NCH*DW-1:0] div_value;
  logic [NCH-1:0]    ce_out;
  logic [NCH-1:0]    tgl_out;
  logic              rst_out;
  logic              locked;
  logic [7:0]        loss_cnt;

  pll_lock_clk_div #(
    .NUM_CH(NCH),
    .DIV_W(DW),
    .LOCK_CYCLES(LC),
    .DEFAULT_DIV(DEF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pll_lock(pll_lock),
    .div_load(div_load),
    .div_value(div_value),
    .ce_out(ce_out),
    .tgl_out(tgl_out),
    .rst_out(rst_out),
    .locked(locked),
    .loss_cnt(loss_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  // Behavioural model
  logic     m_s1, m_ls, m_run;
  int       m_streak, m_loss;
  int       m_act[NCH], m_sh[NCH], m_pos[NCH];
  logic     m_pend[NCH];
  logic [NCH-1:0] m_ce, m_tgl;

  task automatic model_step();
    logic ls_old, was, pulse;
    if (rst) begin
      m_s1 = 0; m_ls = 0; m_run = 0; m_streak = 0; m_loss = 0;
      m_ce = '0; m_tgl = '0;
      for (int i = 0; i < NCH; i++) begin
        m_act[i] = DEF; m_sh[i] = DEF; m_pend[i] = 0; m_pos[i] = 0;
      end
      return;
    end
    ls_old = m_ls;
    m_ls   = m_s1;
    m_s1   = pll_lock;
    was    = m_run;
    if (was) begin
      if (!ls_old) begin
        m_run = 0;
        m_streak = 0;
        if (m_loss < 255) m_loss++;
      end
    end else begin
      m_streak = ls_old ? m_streak + 1 : 0;
      if (m_streak >= LC) begin
        m_run = 1;
        m_streak = 0;
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (!was && m_pend[i]) begin
        m_act[i] = m_sh[i]; m_pend[i] = 0;
      end
      pulse = 0;
      if (m_run) begin
        m_pos[i] = (was ? m_pos[i] : 0) + 1;
        if (m_pos[i] >= m_act[i]) begin
          pulse = 1; m_pos[i] = 0;
        end
      end else begin
        m_pos[i] = 0;
      end
      m_ce[i]  = pulse;
      m_tgl[i] = m_run ? (m_tgl[i] ^ pulse) : 1'b0;
      if (was && pulse && m_pend[i]) begin
        m_act[i] = m_sh[i]; m_pend[i] = 0;
      end
      if (div_load[i]) begin
        m_sh[i] = int'(div_value[i*DW +: DW]); m_pend[i] = 1;
      end
    end
  endtask

  int run_k = 0;

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("ce_out",   32'(ce_out),   32'(m_ce));
    check("tgl_out",  32'(tgl_out),  32'(m_tgl));
    check("rst_out",  32'(rst_out),  32'(!m_run));
    check("locked",   32'(locked),   32'(m_run));
    check("loss_cnt", 32'(loss_cnt), 32'(m_loss));
    run_k = locked ? run_k + 1 : 0;
  endtask

  task automatic wait_locked(input int budget);
    int n = 0;
    while (!locked && n < budget) begin
      cycle();
      n++;
    end
    check("lock_timeout", 32'(locked), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first, e, low_left;
    int cnt[NCH];
    int pulses[$];

    rst = 1; pll_lock = 1; div_load = '0; div_value = '0;
    repeat (3) cycle();

    // Release with lock already high and divisors {1,2,3,5}
    rst = 0;
    div_load = '1;
    div_value = {16'd5, 16'd3, 16'd2, 16'd1};
    first = -1; e = 0;
    while (first < 0 && e < 40) begin
      cycle();
      div_load = '0;
      if (locked) first = e;
      e++;
    end
    check("lock_edge", 32'(first), 32'(LC + 1));

    for (int i = 0; i < NCH; i++) cnt[i] = 0;
    for (int n = 0; n < 40; n++) begin
      if (locked)
        for (int i = 0; i < NCH; i++) cnt[i] += int'(ce_out[i]);
      cycle();
    end
    check("ce_cnt_d1", 32'(cnt[0]), 32'd40);
    check("ce_cnt_d2", 32'(cnt[1]), 32'd20);
    check("ce_cnt_d3", 32'(cnt[2]), 32'd13);
    check("ce_cnt_d5", 32'(cnt[3]), 32'd8);

    // Three-cycle lock drop in RUN
    pll_lock = 0;
    cycle();
    check("drop_edge0", 32'(rst_out), 32'd0);
    cycle();
    check("drop_edge1", 32'(rst_out), 32'd0);
    cycle();
    check("drop_edge2_rst", 32'(rst_out), 32'd1);
    check("drop_edge2_ce",  32'(ce_out),  32'd0);
    check("drop_edge2_tgl", 32'(tgl_out), 32'd0);
    pll_lock = 1;
    check("loss_one", 32'(loss_cnt), 32'd1);
    wait_locked(40);

    // Glitch during STABLE forces full requalification
    pll_lock = 0;
    repeat (5) cycle();
    pll_lock = 1;
    first = -1; e = 0;
    while (first < 0 && e < 40) begin
      cycle();
      if (locked) first = e;
      if (e == 5) pll_lock = 0;
      if (e == 6) pll_lock = 1;
      e++;
    end
    check("glitch_relock", 32'(first), 32'd16);

    // Ch2 D=4, reload to 6 at RUN cycle 2
    pll_lock = 0;
    cycle();
    div_load = 4'b0100;
    div_value = {16'd5, 16'd4, 16'd2, 16'd1};
    cycle();
    div_load = '0;
    repeat (2) cycle();
    pll_lock = 1;
    wait_locked(40);
    e = 0;
    while (run_k < 20 && e < 60) begin
      if (locked && ce_out[2]) pulses.push_back(run_k);
      cycle();
      if (run_k == 2) begin
        div_load = 4'b0100;
        div_value = {16'd5, 16'd6, 16'd2, 16'd1};
      end else begin
        div_load = '0;
      end
      e++;
    end
    check("reload_npulse", 32'(pulses.size()), 32'd3);
    if (pulses.size() >= 3) begin
      check("reload_p0", 32'(pulses[0]), 32'd4);
      check("reload_p1", 32'(pulses[1]), 32'd10);
      check("reload_p2", 32'(pulses[2]), 32'd16);
    end

    // Mid-RUN reset with pending loads
    div_load = '1;
    div_value = {16'd7, 16'd7, 16'd7, 16'd7};
    cycle();
    div_load = '0;
    rst = 1;
    cycle();
    check("rst_rst_out", 32'(rst_out),  32'd1);
    check("rst_locked",  32'(locked),   32'd0);
    check("rst_loss",    32'(loss_cnt), 32'd0);
    rst = 0;
    wait_locked(40);
    first = -1; e = 0;
    while (first < 0 && e < 12) begin
      if (locked && ce_out[3]) first = run_k;
      cycle();
      e++;
    end
    check("rst_default_div", 32'(first), 32'(DEF));

    // Randomized phase
    low_left = 0;
    for (int n = 0; n < 3000; n++) begin
      if (low_left > 0) begin
        pll_lock = 0; low_left--;
      end else begin
        pll_lock = 1;
        if ($urandom_range(0, 59) == 0) low_left = $urandom_range(1, 4);
      end
      for (int i = 0; i < NCH; i++) begin
        div_load[i] = ($urandom_range(0, 7) == 0);
        div_value[i*DW +: DW] = DW'($urandom_range(0, 7));
      end
      rst = ($urandom_range(0, 499) == 0);
      cycle();
    end
    rst = 0; div_load = '0; pll_lock = 1;
    wait_locked(40);

    // Saturation of the loss counter
    for (int n = 0; n < 300; n++) begin
      pll_lock = 0;
      repeat (3) cycle();
      pll_lock = 1;
      wait_locked(40);
    end
    check("loss_sat", 32'(loss_cnt), 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
